// File: rtl/cpu_core_mc.sv
// Multi-cycle RV32I core: one shared memory port, one instruction in flight,
// FETCH -> DECODE -> EXEC -> [MEM] -> WB, with sticky halt/trap stop state.
module cpu_core_mc #(
  parameter int          ADDR_WIDTH = 14,
  parameter logic [31:0] RESET_PC   = 32'h0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_wstrb,
  input  logic                  mem_ready,
  input  logic [31:0]           mem_rdata,
  output logic                  retire,
  output logic                  halt,
  output logic                  trap
);

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, STOP} state_t;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [31:0] INSN_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INSN_EBREAK = 32'h0010_0073;
  localparam logic [ADDR_WIDTH-1:0] CLEAR_BIT0 = {{(ADDR_WIDTH-1){1'b1}}, 1'b0};

  state_t state, next_state;

  logic [ADDR_WIDTH-1:0] pc, next_pc, addr_q;
  logic [31:0] ir, rs1_val, rs2_val, imm, result, wdata_q;
  logic [3:0]  wstrb_q;
  logic [31:0] regs [0:31];

  logic [6:0] opcode, funct7;
  logic [4:0] rd, rs1_idx, rs2_idx;
  logic [2:0] funct3;
  logic is_op, is_load, is_store, is_branch, is_jal, is_jalr;
  logic legal, is_ebreak, writes_rd;
  logic [31:0] imm_dec, alu_in2, alu_out, sra_out, exec_result, pc_ext;
  logic [31:0] st_wdata, load_lane, load_val;
  logic [3:0]  st_wstrb;
  logic [ADDR_WIDTH-1:0] pc_plus4, target_raw, target, ls_addr;
  logic br_taken, taken, ls_misaligned, trap_cond;

  assign opcode    = ir[6:0];
  assign rd        = ir[11:7];
  assign funct3    = ir[14:12];
  assign rs1_idx   = ir[19:15];
  assign rs2_idx   = ir[24:20];
  assign funct7    = ir[31:25];
  assign is_op     = (opcode == OPC_OP);
  assign is_load   = (opcode == OPC_LOAD);
  assign is_store  = (opcode == OPC_STORE);
  assign is_branch = (opcode == OPC_BRANCH);
  assign is_jal    = (opcode == OPC_JAL);
  assign is_jalr   = (opcode == OPC_JALR);

  // Legality is checked against the full RV32I subset; anything unlisted traps.
  always_comb begin
    legal     = 1'b0;
    is_ebreak = 1'b0;
    writes_rd = 1'b0;
    case (opcode)
      OPC_LUI, OPC_AUIPC, OPC_JAL: begin legal = 1'b1; writes_rd = 1'b1; end
      OPC_JALR:   begin legal = (funct3 == 3'd0); writes_rd = 1'b1; end
      OPC_BRANCH: legal = (funct3 != 3'd2) && (funct3 != 3'd3);
      OPC_LOAD:   begin legal = funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}; writes_rd = 1'b1; end
      OPC_STORE:  legal = funct3 inside {3'd0, 3'd1, 3'd2};
      OPC_OPIMM: begin
        writes_rd = 1'b1;
        case (funct3)
          3'd1:    legal = (funct7 == 7'h00);
          3'd5:    legal = (funct7 == 7'h00) || (funct7 == 7'h20);
          default: legal = 1'b1;
        endcase
      end
      OPC_OP: begin
        writes_rd = 1'b1;
        legal = (funct7 == 7'h00) || ((funct7 == 7'h20) && ((funct3 == 3'd0) || (funct3 == 3'd5)));
      end
      OPC_FENCE:  legal = (funct3 == 3'd0);
      OPC_SYSTEM: begin
        legal     = (ir == INSN_ECALL) || (ir == INSN_EBREAK);
        is_ebreak = (ir == INSN_EBREAK);
      end
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    case (opcode)
      OPC_LUI, OPC_AUIPC: imm_dec = {ir[31:12], 12'b0};
      OPC_JAL:    imm_dec = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
      OPC_BRANCH: imm_dec = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      OPC_STORE:  imm_dec = {{20{ir[31]}}, ir[31:25], ir[11:7]};
      default:    imm_dec = {{20{ir[31]}}, ir[31:20]};
    endcase
  end

  assign pc_ext   = 32'(pc);
  assign pc_plus4 = pc + ADDR_WIDTH'(4);
  assign alu_in2  = is_op ? rs2_val : imm;
  assign sra_out  = $signed(rs1_val) >>> alu_in2[4:0];

  always_comb begin
    case (funct3)
      3'd0:    alu_out = (is_op && funct7[5]) ? rs1_val - alu_in2 : rs1_val + alu_in2;
      3'd1:    alu_out = rs1_val << alu_in2[4:0];
      3'd2:    alu_out = {31'b0, $signed(rs1_val) < $signed(alu_in2)};
      3'd3:    alu_out = {31'b0, rs1_val < alu_in2};
      3'd4:    alu_out = rs1_val ^ alu_in2;
      3'd5:    alu_out = funct7[5] ? sra_out : rs1_val >> alu_in2[4:0];
      3'd6:    alu_out = rs1_val | alu_in2;
      default: alu_out = rs1_val & alu_in2;
    endcase
  end

  always_comb begin
    case (funct3)
      3'd0:    br_taken = (rs1_val == rs2_val);
      3'd1:    br_taken = (rs1_val != rs2_val);
      3'd4:    br_taken = $signed(rs1_val) < $signed(rs2_val);
      3'd5:    br_taken = $signed(rs1_val) >= $signed(rs2_val);
      3'd6:    br_taken = rs1_val < rs2_val;
      3'd7:    br_taken = rs1_val >= rs2_val;
      default: br_taken = 1'b0;
    endcase
  end

  // Bit 0 is cleared for JALR; for JAL/branches it is already zero.
  assign target_raw    = ADDR_WIDTH'((is_jalr ? rs1_val : pc_ext) + imm);
  assign target        = target_raw & CLEAR_BIT0;
  assign taken         = is_jal || is_jalr || (is_branch && br_taken);
  assign ls_addr       = ADDR_WIDTH'(rs1_val + imm);
  assign ls_misaligned = ((funct3[1:0] == 2'd2) && (ls_addr[1:0] != 2'd0)) ||
                         ((funct3[1:0] == 2'd1) && ls_addr[0]);
  assign trap_cond     = !legal || ((is_load || is_store) && ls_misaligned) || (taken && target[1]);

  always_comb begin
    case (opcode)
      OPC_LUI:           exec_result = imm;
      OPC_AUIPC:         exec_result = pc_ext + imm;
      OPC_JAL, OPC_JALR: exec_result = 32'(pc_plus4);
      default:           exec_result = alu_out;
    endcase
  end

  always_comb begin
    case (funct3[1:0])
      2'd0: begin
        st_wdata = {4{rs2_val[7:0]}};
        st_wstrb = 4'b0001 << ls_addr[1:0];
      end
      2'd1: begin
        st_wdata = {2{rs2_val[15:0]}};
        st_wstrb = ls_addr[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        st_wdata = rs2_val;
        st_wstrb = 4'b1111;
      end
    endcase
  end

  assign load_lane = mem_rdata >> {addr_q[1:0], 3'b000};
  always_comb begin
    case (funct3)
      3'd0:    load_val = {{24{load_lane[7]}}, load_lane[7:0]};
      3'd1:    load_val = {{16{load_lane[15]}}, load_lane[15:0]};
      3'd4:    load_val = {24'b0, load_lane[7:0]};
      3'd5:    load_val = {16'b0, load_lane[15:0]};
      default: load_val = load_lane;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= FETCH;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      FETCH:  if (mem_ready) next_state = DECODE;
      DECODE: next_state = EXEC;
      EXEC: begin
        if (trap_cond || is_ebreak)   next_state = STOP;
        else if (is_load || is_store) next_state = MEM;
        else                          next_state = WB;
      end
      MEM:    if (mem_ready) next_state = WB;
      WB:     next_state = FETCH;
      STOP:   next_state = STOP;
      default: next_state = FETCH;
    endcase
  end

  // Bus outputs are gated by rst so an in-flight request drops immediately.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    retire    = 1'b0;
    if (!rst) begin
      case (state)
        FETCH: begin
          mem_req  = 1'b1;
          mem_addr = pc;
        end
        MEM: begin
          mem_req  = 1'b1;
          mem_addr = addr_q;
          if (is_store) begin
            mem_we    = 1'b1;
            mem_wdata = wdata_q;
            mem_wstrb = wstrb_q;
          end
        end
        WB:      retire = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc      <= RESET_PC[ADDR_WIDTH-1:0];
      next_pc <= '0;
      addr_q  <= '0;
      ir      <= '0;
      rs1_val <= '0;
      rs2_val <= '0;
      imm     <= '0;
      result  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      halt    <= 1'b0;
      trap    <= 1'b0;
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else begin
      case (state)
        FETCH: if (mem_ready) ir <= mem_rdata;
        DECODE: begin
          rs1_val <= (rs1_idx == 5'd0) ? 32'h0 : regs[rs1_idx];
          rs2_val <= (rs2_idx == 5'd0) ? 32'h0 : regs[rs2_idx];
          imm     <= imm_dec;
        end
        EXEC: begin
          result  <= exec_result;
          next_pc <= taken ? target : pc_plus4;
          addr_q  <= ls_addr;
          wdata_q <= st_wdata;
          wstrb_q <= st_wstrb;
          if (trap_cond)      trap <= 1'b1;
          else if (is_ebreak) halt <= 1'b1;
        end
        MEM: if (mem_ready && is_load) result <= load_val;
        WB: begin
          pc <= next_pc;
          if (writes_rd && (rd != 5'd0)) regs[rd] <= result;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_core_mc.sv
// Directed bench for cpu_core_mc: word memory model, hand-assembled programs,
// cycle-accurate retire/bus checks through a single checking task.
module tb_cpu_core_mc;

  localparam int AW = 14;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          mem_req, mem_we, mem_ready, retire, halt, trap;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata, mem_rdata;
  logic [3:0]    mem_wstrb;

  logic [31:0] mem [0:4095];

  int tests = 0;
  int fails = 0;

  int          cyc;
  int          n_req;
  int          unstable;
  int          retire_cyc[$];
  logic [31:0] req_addr[$];
  logic        first_req;
  logic [31:0] first_addr;
  logic [31:0] st_addr, st_wdata;
  logic [3:0]  st_wstrb;
  int          n_store;

  cpu_core_mc #(.ADDR_WIDTH(AW), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .retire(retire), .halt(halt), .trap(trap)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[13:2]];

  // Byte-strobed store into the memory model.
  always @(posedge clk) begin
    if (mem_req && mem_ready && mem_we) begin
      for (int b = 0; b < 4; b++)
        if (mem_wstrb[b]) mem[mem_addr[13:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic int rcyc(input int i);
    return (i < retire_cyc.size()) ? retire_cyc[i] : -1;
  endfunction

  function automatic logic [31:0] raddr(input int i);
    return (i < req_addr.size()) ? req_addr[i] : 32'hDEAD_BEEF;
  endfunction

  task automatic clearMem();
    for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
  endtask

  // Assert rst for two edges; returns while rst is still high for checking.
  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    mem_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
  endtask

  // Releases rst and runs until a few cycles into STOP, or max_cycles.
  // mem_ready is low for cycles 1..stall_n (cycle 1 = first cycle after release).
  task automatic applyStimulus(input int max_cycles, input int stall_n);
    int   extra;
    logic prev_stall;
    logic [31:0] prev_addr;
    retire_cyc.delete();
    req_addr.delete();
    n_req = 0; n_store = 0; unstable = 0; extra = 0;
    prev_stall = 1'b0; prev_addr = 32'h0;
    st_addr = 32'h0; st_wdata = 32'h0; st_wstrb = 4'h0;
    rst = 1'b0;
    mem_ready = (stall_n > 0) ? 1'b0 : 1'b1;
    #1;
    cyc = 1;
    first_req  = mem_req;
    first_addr = 32'(mem_addr);
    while (cyc <= max_cycles && extra < 6) begin
      if (retire) retire_cyc.push_back(cyc);
      if (prev_stall && (!mem_req || 32'(mem_addr) != prev_addr)) unstable++;
      if (mem_req && mem_ready) begin
        n_req++;
        req_addr.push_back(32'(mem_addr));
        if (mem_we) begin
          n_store++;
          st_addr  = 32'(mem_addr);
          st_wdata = mem_wdata;
          st_wstrb = mem_wstrb;
        end
      end
      prev_stall = mem_req && !mem_ready;
      prev_addr  = 32'(mem_addr);
      if (halt || trap) extra++;
      @(negedge clk);
      mem_ready = (cyc + 1 <= stall_n) ? 1'b0 : 1'b1;
      #1;
      cyc++;
    end
    checkOutput("run_finished", 32'(halt | trap), 32'h1);
  endtask

  task automatic loadProgramA();
    clearMem();
    mem[0] = 32'h0050_0093;  // addi x1,x0,5
    mem[1] = 32'h0010_8133;  // add  x2,x1,x1
    mem[2] = 32'h0010_0073;  // ebreak
  endtask

  initial begin
    int idle_req;
    mem_ready = 1'b1;

    // Reset values and the basic add program.
    loadProgramA();
    doReset();
    checkOutput("rst_mem_req", 32'(mem_req), 32'h0);
    checkOutput("rst_mem_addr", 32'(mem_addr), 32'h0);
    checkOutput("rst_mem_we", 32'(mem_we), 32'h0);
    checkOutput("rst_retire", 32'(retire), 32'h0);
    checkOutput("rst_halt", 32'(halt), 32'h0);
    checkOutput("rst_trap", 32'(trap), 32'h0);
    applyStimulus(60, 0);
    checkOutput("A_first_req", 32'(first_req), 32'h1);
    checkOutput("A_first_addr", first_addr, 32'h0);
    checkOutput("A_retire_cnt", 32'(retire_cyc.size()), 32'd2);
    checkOutput("A_retire0_cyc", 32'(rcyc(0)), 32'd4);
    checkOutput("A_retire1_cyc", 32'(rcyc(1)), 32'd8);
    checkOutput("A_x1", dut.regs[1], 32'h0000_0005);
    checkOutput("A_x2", dut.regs[2], 32'h0000_000A);
    checkOutput("A_halt", 32'(halt), 32'h1);
    checkOutput("A_trap", 32'(trap), 32'h0);
    checkOutput("A_stop_req", 32'(mem_req), 32'h0);

    // Byte store lane/strobe, then misaligned word store traps.
    clearMem();
    mem[0] = 32'h1234_B137;  // lui  x2,0x1234B
    mem[1] = 32'hBCD1_0113;  // addi x2,x2,-1075
    mem[2] = 32'h0020_01A3;  // sb   x2,3(x0)
    mem[3] = 32'h0020_2123;  // sw   x2,2(x0)
    doReset();
    checkOutput("B_rst_halt_clr", 32'(halt), 32'h0);
    applyStimulus(80, 0);
    checkOutput("B_x2", dut.regs[2], 32'h1234_ABCD);
    checkOutput("B_store_cnt", 32'(n_store), 32'd1);
    checkOutput("B_sb_addr", st_addr, 32'h0000_0003);
    checkOutput("B_sb_wstrb", 32'(st_wstrb), 32'h8);
    checkOutput("B_sb_wdata", st_wdata, 32'hCDCD_CDCD);
    checkOutput("B_req_cnt", 32'(n_req), 32'd5);
    checkOutput("B_trap", 32'(trap), 32'h1);
    checkOutput("B_halt", 32'(halt), 32'h0);
    checkOutput("B_retire_cnt", 32'(retire_cyc.size()), 32'd3);
    checkOutput("B_pc_held", 32'(dut.pc), 32'h0000_000C);
    checkOutput("B_sb_mem", mem[0][31:24], 32'h0000_00CD);

    // Load lane selection with sign/zero extension.
    clearMem();
    mem[0] = 32'h0120_0183;  // lb  x3,18(x0)
    mem[1] = 32'h0120_4203;  // lbu x4,18(x0)
    mem[2] = 32'h0120_5283;  // lhu x5,18(x0)
    mem[3] = 32'h0010_0073;  // ebreak
    mem[4] = 32'h80FF_0000;
    doReset();
    checkOutput("C_rst_trap_clr", 32'(trap), 32'h0);
    applyStimulus(80, 0);
    checkOutput("C_lb", dut.regs[3], 32'hFFFF_FFFF);
    checkOutput("C_lbu", dut.regs[4], 32'h0000_00FF);
    checkOutput("C_lhu", dut.regs[5], 32'h0000_80FF);
    checkOutput("C_retire0_cyc", 32'(rcyc(0)), 32'd5);
    checkOutput("C_retire2_cyc", 32'(rcyc(2)), 32'd15);
    checkOutput("C_load_addr", raddr(1), 32'h0000_0012);

    // Three wait cycles on the first fetch.
    loadProgramA();
    doReset();
    applyStimulus(60, 3);
    checkOutput("D_stall_stable", 32'(unstable), 32'd0);
    checkOutput("D_retire0_cyc", 32'(rcyc(0)), 32'd7);
    checkOutput("D_retire1_cyc", 32'(rcyc(1)), 32'd11);
    checkOutput("D_x2", dut.regs[2], 32'h0000_000A);

    // Reset during a stalled fetch aborts it and refetches from RESET_PC.
    loadProgramA();
    doReset();
    rst = 1'b0;
    mem_ready = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("E_stalled_req", 32'(mem_req), 32'h1);
    rst = 1'b1;
    @(negedge clk);
    #1;
    checkOutput("E_req_after_rst", 32'(mem_req), 32'h0);
    checkOutput("E_x2_cleared", dut.regs[2], 32'h0);
    applyStimulus(60, 0);
    checkOutput("E_refetch_addr", raddr(0), 32'h0);
    checkOutput("E_retire0_cyc", 32'(rcyc(0)), 32'd4);
    checkOutput("E_x2", dut.regs[2], 32'h0000_000A);

    // ALU ops, taken bne skipping one instruction, jalr.
    clearMem();
    mem[0]  = 32'hFF80_0093;  // addi x1,x0,-8
    mem[1]  = 32'h0030_0113;  // addi x2,x0,3
    mem[2]  = 32'h4020_81B3;  // sub  x3,x1,x2
    mem[3]  = 32'h0020_A233;  // slt  x4,x1,x2
    mem[4]  = 32'h0020_B2B3;  // sltu x5,x1,x2
    mem[5]  = 32'h4020_D333;  // sra  x6,x1,x2
    mem[6]  = 32'h01C0_D393;  // srli x7,x1,28
    mem[7]  = 32'h0021_1433;  // sll  x8,x2,x2
    mem[8]  = 32'h0F00_C493;  // xori x9,x1,0xF0
    mem[9]  = 32'h0020_9463;  // bne  x1,x2,+8
    mem[10] = 32'h0010_0513;  // addi x10,x0,1 (skipped)
    mem[11] = 32'h0390_0613;  // addi x12,x0,57
    mem[12] = 32'h0006_05E7;  // jalr x11,0(x12)
    mem[13] = 32'h0020_0513;  // addi x10,x0,2 (skipped)
    mem[14] = 32'h0010_0073;  // ebreak
    doReset();
    applyStimulus(200, 0);
    checkOutput("F_sub", dut.regs[3], 32'hFFFF_FFF5);
    checkOutput("F_slt", dut.regs[4], 32'h0000_0001);
    checkOutput("F_sltu", dut.regs[5], 32'h0000_0000);
    checkOutput("F_sra", dut.regs[6], 32'hFFFF_FFFF);
    checkOutput("F_srli", dut.regs[7], 32'h0000_000F);
    checkOutput("F_sll", dut.regs[8], 32'h0000_0018);
    checkOutput("F_xori", dut.regs[9], 32'hFFFF_FF08);
    checkOutput("F_skipped", dut.regs[10], 32'h0);
    checkOutput("F_jalr_link", dut.regs[11], 32'h0000_0034);
    checkOutput("F_retire_cnt", 32'(retire_cyc.size()), 32'd12);
    checkOutput("F_halt", 32'(halt), 32'h1);

    // Backward jal wraps the PC; misaligned branch target traps.
    clearMem();
    mem[0]     = 32'hFFDF_F0EF;  // jal x1,-4
    mem[12'hFFF] = 32'h0000_0163;  // beq x0,x0,+2
    doReset();
    applyStimulus(60, 0);
    checkOutput("G_link", dut.regs[1], 32'h0000_0004);
    checkOutput("G_wrap_fetch", raddr(1), 32'h0000_3FFC);
    checkOutput("G_trap", 32'(trap), 32'h1);
    checkOutput("G_pc_held", 32'(dut.pc), 32'h0000_3FFC);
    checkOutput("G_retire_cnt", 32'(retire_cyc.size()), 32'd1);

    // All-zero instruction traps and the core stays off the bus.
    clearMem();
    doReset();
    applyStimulus(60, 0);
    checkOutput("H_trap", 32'(trap), 32'h1);
    checkOutput("H_halt", 32'(halt), 32'h0);
    checkOutput("H_req_cnt", 32'(n_req), 32'd1);
    checkOutput("H_retire_cnt", 32'(retire_cyc.size()), 32'd0);
    idle_req = 0;
    repeat (10) begin
      @(negedge clk);
      #1;
      if (mem_req) idle_req++;
    end
    checkOutput("H_stop_idle", 32'(idle_req), 32'd0);
    checkOutput("H_trap_sticky", 32'(trap), 32'h1);
    doReset();
    checkOutput("H_rst_clears_trap", 32'(trap), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
